mem_port_arbiter: RTL



---
 rtl/mem_arb_pkg.sv | 29 ++
 rtl/rr_pick.sv | 36 +++
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-port arbiter.
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin selection;
// fixed lowest-index priority is used otherwise.
package mem_arb_pkg;

    // Largest supported number of requesters
    localparam int MAX_PORTS = 8;
    localparam int MAX_IDX_W = 3;

    // Arbiter state: free for arbitration, or held by one owner port
    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Convert a one-hot (or zero) vector into the index of its set bit.
    // A zero vector maps to index 0.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (oh[i]) begin
                idx = idx | MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational first-set-bit picker: finds the first asserted request at or
// after a base index, wrapping modulo N, and returns a one-hot grant plus index.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] base,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic [MAX_PORTS-1:0] grant_wide;

    // Scan from base upward with wrap; the first requester found wins
    always_comb begin : pick_blk
        int   p;
        logic found;
        p     = 0;
        found = 1'b0;
        grant = '0;
        for (int k = 0; k < N; k++) begin
            p = (int'(base) + k) % N;
            if (!found && req[p]) begin
                grant[p] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign grant_wide = MAX_PORTS'(grant);
    assign idx        = IW'(onehot_to_idx(grant_wide));

endmodule

// File: rtl/mem_port_arbiter.sv
// Registered memory-port arbiter: merges NUM_PORTS requesters onto a single
// data-memory port with valid/ready handshakes and an optional owner lock.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// without it the lowest requesting index wins.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 15,
    parameter int ID_W      = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          req,
    input  logic [NUM_PORTS-1:0]          lock,
    input  logic [NUM_PORTS-1:0]          we,
    input  logic [NUM_PORTS*ADDR_W-1:0]   addr_in,
    input  logic [NUM_PORTS*DATA_W-1:0]   data_in,
    output logic [NUM_PORTS-1:0]          accept,
    output logic [DATA_W-1:0]             out,
    output logic                          write,
    output logic [ADDR_W-1:0]             address,
    output logic                          valid,
    output logic [ID_W-1:0]               port_id,
    output logic                          locked
);

    arb_state_t      state_reg, state_next;
    logic [ID_W-1:0] owner_reg, owner_next;

    logic [NUM_PORTS-1:0] pick_grant;
    logic [ID_W-1:0]      pick_idx;
    logic [ID_W-1:0]      base;
    logic [ID_W-1:0]      win_idx;
    logic                 xfer;

    logic [ADDR_W-1:0] addr_arr [NUM_PORTS];
    logic [DATA_W-1:0] data_arr [NUM_PORTS];

    // Unpack the flat per-port buses into indexable arrays
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
            assign addr_arr[gi] = addr_in[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi] = data_in[gi*DATA_W +: DATA_W];
        end
    endgenerate

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] ptr_reg, ptr_next;

    assign base = ptr_reg;

    // Pointer moves just past the winner of each transfer made while open
    always_comb begin
        ptr_next = ptr_reg;
        if (xfer && state_reg == ARB_OPEN) begin
            if (win_idx == ID_W'(NUM_PORTS - 1)) begin
                ptr_next = '0;
            end else begin
                ptr_next = win_idx + ID_W'(1);
            end
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end
`else
    assign base = '0;
`endif

    rr_pick #(
        .N  (NUM_PORTS),
        .IW (ID_W)
    ) u_pick (
        .req   (req),
        .base  (base),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // FSM state register: arbitration state and lock owner
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ARB_OPEN;
            owner_reg <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
        end
    end

    // FSM next state: enter lock on a locking transfer, leave on release or idle owner
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        case (state_reg)
            ARB_OPEN: begin
                if (xfer && lock[win_idx]) begin
                    state_next = ARB_LOCKED;
                    owner_next = win_idx;
                end
            end
            ARB_LOCKED: begin
                if (!req[owner_reg] || !lock[owner_reg]) begin
                    state_next = ARB_OPEN;
                end
            end
            default: begin
                state_next = ARB_OPEN;
            end
        endcase
    end

    // FSM outputs: accept comes only from state and req, never from the datapath
    always_comb begin
        accept  = '0;
        win_idx = pick_idx;
        if (state_reg == ARB_LOCKED) begin
            win_idx          = owner_reg;
            accept[owner_reg] = req[owner_reg];
        end else begin
            accept = pick_grant;
        end
    end

    assign xfer   = |accept;
    assign locked = (state_reg == ARB_LOCKED);

    // Memory-side register stage: capture the winner's transfer, hold data when idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out     <= '0;
            address <= '0;
            write   <= 1'b0;
            valid   <= 1'b0;
            port_id <= '0;
        end else begin
            valid <= xfer;
            write <= xfer & we[win_idx];
            if (xfer) begin
                out     <= data_arr[win_idx];
                address <= addr_arr[win_idx];
                port_id <= win_idx;
            end
        end
    end

endmodule
